// File: rtl/sem_image_writer_if.sv
// Handshake bundle between the image writer and its semafor mailbox bank.
// The writer uses the master view; a mailbox bank or test driver uses the slave view.
interface sem_image_writer_if #(
  parameter int N = 8
) ();
  logic         start;
  logic [N-1:0] image;
  logic [N-1:0] wr_rdy;
  logic [N-1:0] wr;
  logic [N-1:0] di;
  logic         busy;
  logic         done;
  logic         err;
  logic [N-1:0] err_mask;

  modport master (
    input  start, image, wr_rdy,
    output wr, di, busy, done, err, err_mask
  );

  modport slave (
    output start, image, wr_rdy,
    input  wr, di, busy, done, err, err_mask
  );
endinterface

// File: rtl/sem_image_writer.sv
// Snapshots the output process image on start and writes it to N 1-bit semafor mailboxes
// one channel at a time, skipping channels that stay not-ready for TIMEOUT cycles.
module sem_image_writer #(
  parameter int N              = 8,
  parameter int TIMEOUT        = 255,
  parameter int SKIP_UNCHANGED = 1
) (
  input logic clk,
  input logic rst,
  sem_image_writer_if.master bus
);

  localparam int IDX_W = $clog2(N);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [TMO_W-1:0] tmo;
  logic [N-1:0]     snapshot;
  logic [N-1:0]     last;
  logic [N-1:0]     err_mask;
  logic [N-1:0]     wr_vec;

  logic skip;
  logic rdy;
  logic timeout;
  logic advance;

  // skip wins over ready, ready wins over timeout on the final wait cycle
  assign skip    = (SKIP_UNCHANGED != 0) && (snapshot[idx] == last[idx]);
  assign rdy     = bus.wr_rdy[idx];
  assign timeout = (tmo == TMO_LAST);
  assign advance = skip || rdy || timeout;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SEND;
      SEND:    if (advance && (idx == LAST_IDX)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      tmo      <= '0;
      snapshot <= '0;
      last     <= '0;
      err_mask <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            snapshot <= bus.image;
            err_mask <= '0;
            idx      <= '0;
            tmo      <= '0;
          end
        end
        SEND: begin
          if (!skip && rdy)          last[idx]     <= snapshot[idx];
          else if (!skip && timeout) err_mask[idx] <= 1'b1;
          if (advance) begin
            tmo <= '0;
            if (idx != LAST_IDX) idx <= idx + 1'b1;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // write strobe is combinational so the handshake closes in the same cycle
  always_comb begin
    wr_vec = '0;
    if ((state == SEND) && !rst && rdy && !skip)
      wr_vec = {{(N-1){1'b0}}, 1'b1} << idx;
  end

  assign bus.wr       = wr_vec;
  assign bus.di       = snapshot;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == FIN);
  assign bus.err      = (state == FIN) && (|err_mask);
  assign bus.err_mask = err_mask;

endmodule
